// File: rtl/stack_tracker.sv
// Stacking-game tracker: catches/misses a falling item against a player tower, keeps score and lives.
// Optional macro COLOR_MATCH_BONUS_EN: a same-colour landing on a non-empty tower scores 2 instead of 1.
module stack_tracker #(
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned PLAT_Y       = 440,
    parameter int unsigned ITEM_H       = 16,
    parameter int unsigned CATCH_HALF_W = 24,
    parameter int unsigned MAX_STACK    = 8,
    parameter int unsigned LIVES        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    input  logic       item_valid,
    input  logic [9:0] item_x,
    input  logic [9:0] item_y,
    input  logic [1:0] item_color,
    input  logic [9:0] player_x,
    output logic       land_pulse,
    output logic       miss_pulse,
    output logic       respawn,
    output logic [3:0] stack_height,
    output logic [1:0] top_color,
    output logic [9:0] surface_y,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over
);

    localparam int unsigned IDXW = (MAX_STACK > 1) ? $clog2(MAX_STACK) : 1;

    typedef enum logic [1:0] {
        S_TRACK = 2'd0,
        S_LAND  = 2'd1,
        S_MISS  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [3:0]  r_height;
    logic [1:0]  r_colors [MAX_STACK];
    logic [1:0]  r_item_color;
    logic [9:0]  r_surface_y;
    logic [7:0]  r_score;
    logic [1:0]  r_lives;
    logic        r_game_over;
    logic        r_land_pulse;
    logic        r_miss_pulse;
    logic        r_respawn;

    logic [10:0] w_bottom;
    logic [10:0] w_dx;
    logic [10:0] w_adx;
    logic        w_catch;
    logic        w_missed;
    logic [1:0]  w_top;
    logic        w_tower;
    logic [3:0]  w_height_next;
    logic [8:0]  w_add;
    logic [8:0]  w_score_sum;

    // Catch/miss geometry; the x distance is taken as an 11-bit magnitude
    assign w_bottom = {1'b0, item_y} + 11'(ITEM_H);
    assign w_dx     = {1'b0, item_x} - {1'b0, player_x};
    assign w_adx    = w_dx[10] ? (11'd0 - w_dx) : w_dx;
    assign w_catch  = (w_bottom >= {1'b0, r_surface_y}) && (w_adx <= 11'(CATCH_HALF_W));
    assign w_missed = ({1'b0, item_y} >= 11'(SCREEN_H));

    always_comb begin
        w_top = 2'd0;
        if (r_height != 4'd0) begin
            w_top = r_colors[IDXW'(r_height - 4'd1)];
        end
    end

    assign w_tower       = ((r_height + 4'd1) == 4'(MAX_STACK));
    assign w_height_next = w_tower ? 4'd0 : (r_height + 4'd1);

    always_comb begin
        w_add = 9'd1;
`ifdef COLOR_MATCH_BONUS_EN
        if ((r_height != 4'd0) && (r_item_color == w_top)) begin
            w_add = 9'd2;
        end
`endif
        if (w_tower) begin
            w_add = w_add + 9'd4;
        end
        w_score_sum = {1'b0, r_score} + w_add;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_TRACK;
        end else begin
            r_state <= w_next;
        end
    end

    // LAND takes priority over MISS; LAND/MISS always complete in one cycle, even when paused
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_TRACK: begin
                if (item_valid && !pause) begin
                    if (w_catch) begin
                        w_next = S_LAND;
                    end else if (w_missed) begin
                        w_next = S_MISS;
                    end
                end
            end
            S_LAND:  w_next = S_TRACK;
            S_MISS:  w_next = (r_lives <= 2'd1) ? S_OVER : S_TRACK;
            S_OVER:  w_next = S_OVER;
            default: w_next = S_TRACK;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_height     <= 4'd0;
            r_colors     <= '{default: 2'd0};
            r_item_color <= 2'd0;
            r_surface_y  <= 10'(PLAT_Y);
            r_score      <= 8'd0;
            r_lives      <= 2'(LIVES);
            r_game_over  <= 1'b0;
            r_land_pulse <= 1'b0;
            r_miss_pulse <= 1'b0;
            r_respawn    <= 1'b0;
        end else begin
            r_land_pulse <= 1'b0;
            r_miss_pulse <= 1'b0;
            r_respawn    <= 1'b0;
            if ((r_state == S_TRACK) && (w_next == S_LAND)) begin
                r_item_color <= item_color;
            end
            case (r_state)
                S_LAND: begin
                    r_colors[IDXW'(r_height)] <= r_item_color;
                    r_height     <= w_height_next;
                    r_surface_y  <= 10'(PLAT_Y) - 10'(w_height_next * ITEM_H);
                    r_score      <= w_score_sum[8] ? 8'd255 : w_score_sum[7:0];
                    r_land_pulse <= 1'b1;
                    r_respawn    <= 1'b1;
                end
                S_MISS: begin
                    if (r_lives != 2'd0) begin
                        r_lives <= r_lives - 2'd1;
                    end
                    if (r_lives <= 2'd1) begin
                        r_game_over <= 1'b1;
                    end
                    r_miss_pulse <= 1'b1;
                    r_respawn    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign land_pulse   = r_land_pulse;
    assign miss_pulse   = r_miss_pulse;
    assign respawn      = r_respawn;
    assign stack_height = r_height;
    assign top_color    = w_top;
    assign surface_y    = r_surface_y;
    assign score        = r_score;
    assign lives        = r_lives;
    assign game_over    = r_game_over;

endmodule

// File: tb/tb_stack_tracker.sv
// Directed self-checking bench for stack_tracker with default parameters.
module tb_stack_tracker;

    logic       clk;
    logic       rst;
    logic       pause;
    logic       item_valid;
    logic [9:0] item_x;
    logic [9:0] item_y;
    logic [1:0] item_color;
    logic [9:0] player_x;
    logic       land_pulse;
    logic       miss_pulse;
    logic       respawn;
    logic [3:0] stack_height;
    logic [1:0] top_color;
    logic [9:0] surface_y;
    logic [7:0] score;
    logic [1:0] lives;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    stack_tracker dut (
        .clk         (clk),
        .rst         (rst),
        .pause       (pause),
        .item_valid  (item_valid),
        .item_x      (item_x),
        .item_y      (item_y),
        .item_color  (item_color),
        .player_x    (player_x),
        .land_pulse  (land_pulse),
        .miss_pulse  (miss_pulse),
        .respawn     (respawn),
        .stack_height(stack_height),
        .top_color   (top_color),
        .surface_y   (surface_y),
        .score       (score),
        .lives       (lives),
        .game_over   (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe one item and sample the outputs #1 after the edge where the event must be visible
    task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [1:0] c, input logic p,
                        output logic lp, output logic mp, output logic rs);
        @(negedge clk);
        item_x = x; item_y = y; item_color = c; pause = p; item_valid = 1'b1;
        @(negedge clk);
        item_valid = 1'b0;
        @(posedge clk);
        #1;
        lp = land_pulse; mp = miss_pulse; rs = respawn;
        @(negedge clk);
        pause = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; item_valid = 1'b0; pause = 1'b0; player_x = 10'd300;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({land_pulse, miss_pulse, respawn, stack_height, top_color, surface_y, score, lives, game_over}
            !== {1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 10'd440, 8'd0, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL reset: got h=%0d top=%0d surf=%0d score=%0d lives=%0d go=%0d pulses=%b%b%b, want 0 0 440 0 3 0 000",
                     stack_height, top_color, surface_y, score, lives, game_over, land_pulse, miss_pulse, respawn);
        end
    endtask

    task automatic test_catch();
        logic lp, mp, rs;
        do_reset();
        send(10'd310, 10'd424, 2'd2, 1'b0, lp, mp, rs);
        checks++;
        if ({lp, mp, rs} !== 3'b101) begin
            errors++; $display("FAIL catch_pulse: got lp/mp/rs=%b%b%b want 101", lp, mp, rs);
        end
        checks++;
        if ({stack_height, surface_y, score, top_color} !== {4'd1, 10'd424, 8'd1, 2'd2}) begin
            errors++;
            $display("FAIL catch_state: got h=%0d surf=%0d score=%0d top=%0d want 1 424 1 2",
                     stack_height, surface_y, score, top_color);
        end
        @(posedge clk); #1;
        checks++;
        if ({land_pulse, respawn} !== 2'b00) begin
            errors++; $display("FAIL catch_width: pulses still %b%b one cycle later, want 00", land_pulse, respawn);
        end
    endtask

    task automatic test_miss();
        logic lp, mp, rs;
        do_reset();
        send(10'd310, 10'd424, 2'd1, 1'b0, lp, mp, rs);
        send(10'd100, 10'd480, 2'd1, 1'b0, lp, mp, rs);
        checks++;
        if ({lp, mp, rs} !== 3'b011) begin
            errors++; $display("FAIL miss_pulse: got lp/mp/rs=%b%b%b want 011", lp, mp, rs);
        end
        checks++;
        if ({lives, stack_height, game_over} !== {2'd2, 4'd1, 1'b0}) begin
            errors++; $display("FAIL miss_state: got lives=%0d h=%0d go=%0d want 2 1 0", lives, stack_height, game_over);
        end
    endtask

    task automatic test_boundaries();
        logic lp, mp, rs;
        do_reset();
        send(10'd325, 10'd424, 2'd0, 1'b0, lp, mp, rs);
        checks++;
        if ({lp, mp, rs, stack_height} !== {3'b000, 4'd0}) begin
            errors++; $display("FAIL dx25_nocatch: got pulses=%b%b%b h=%0d want 000 0", lp, mp, rs, stack_height);
        end
        send(10'd300, 10'd423, 2'd0, 1'b0, lp, mp, rs);
        checks++;
        if ({lp, mp, rs, stack_height} !== {3'b000, 4'd0}) begin
            errors++; $display("FAIL y423_nocatch: got pulses=%b%b%b h=%0d want 000 0", lp, mp, rs, stack_height);
        end
        send(10'd276, 10'd424, 2'd3, 1'b0, lp, mp, rs);
        checks++;
        if ({lp, stack_height, top_color} !== {1'b1, 4'd1, 2'd3}) begin
            errors++; $display("FAIL dxm24_catch: got lp=%b h=%0d top=%0d want 1 1 3", lp, stack_height, top_color);
        end
        send(10'd300, 10'd480, 2'd0, 1'b0, lp, mp, rs);
        checks++;
        if ({lp, mp, lives, stack_height} !== {2'b10, 2'd3, 4'd2}) begin
            errors++;
            $display("FAIL land_priority: got lp=%b mp=%b lives=%0d h=%0d want 1 0 3 2", lp, mp, lives, stack_height);
        end
    endtask

    task automatic test_game_over();
        logic lp, mp, rs;
        logic [1:0] exp_lives;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(10'd100, 10'd500, 2'd0, 1'b0, lp, mp, rs);
            exp_lives = 2'd2 - 2'(i);
            checks++;
            if ({mp, lives} !== {1'b1, exp_lives}) begin
                errors++; $display("FAIL miss_%0d: got mp=%b lives=%0d want 1 %0d", i, mp, lives, exp_lives);
            end
        end
        checks++;
        if (game_over !== 1'b1) begin
            errors++; $display("FAIL game_over: got %b want 1", game_over);
        end
        send(10'd300, 10'd424, 2'd1, 1'b0, lp, mp, rs);
        checks++;
        if ({lp, mp, rs, score, stack_height, game_over} !== {3'b000, 8'd0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL over_sticky: got pulses=%b%b%b score=%0d h=%0d go=%b want 000 0 0 1",
                     lp, mp, rs, score, stack_height, game_over);
        end
    endtask

    task automatic test_tower();
        logic lp, mp, rs;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(10'd300, 10'(424 - 16 * i), 2'(i % 4), 1'b0, lp, mp, rs);
        end
        checks++;
        if ({stack_height, score, surface_y, top_color} !== {4'd0, 8'd12, 10'd440, 2'd0}) begin
            errors++;
            $display("FAIL tower: got h=%0d score=%0d surf=%0d top=%0d want 0 12 440 0",
                     stack_height, score, surface_y, top_color);
        end
    endtask

    task automatic test_bonus();
        logic lp, mp, rs;
        logic [7:0] exp_score;
`ifdef COLOR_MATCH_BONUS_EN
        exp_score = 8'd3;
`else
        exp_score = 8'd2;
`endif
        do_reset();
        send(10'd300, 10'd424, 2'd1, 1'b0, lp, mp, rs);
        send(10'd300, 10'd408, 2'd1, 1'b0, lp, mp, rs);
        checks++;
        if ({score, stack_height, surface_y} !== {exp_score, 4'd2, 10'd408}) begin
            errors++;
            $display("FAIL same_colour: got score=%0d h=%0d surf=%0d want %0d 2 408",
                     score, stack_height, surface_y, exp_score);
        end
    endtask

    task automatic test_pause();
        logic lp, mp, rs;
        do_reset();
        send(10'd300, 10'd424, 2'd1, 1'b1, lp, mp, rs);
        checks++;
        if ({lp, mp, rs, stack_height, score, lives} !== {3'b000, 4'd0, 8'd0, 2'd3}) begin
            errors++;
            $display("FAIL pause_hold: got pulses=%b%b%b h=%0d score=%0d lives=%0d want 000 0 0 3",
                     lp, mp, rs, stack_height, score, lives);
        end
    endtask

    task automatic test_reset_mid_land();
        logic lp, mp, rs;
        do_reset();
        send(10'd300, 10'd424, 2'd2, 1'b0, lp, mp, rs);
        @(negedge clk);
        item_x = 10'd300; item_y = 10'd408; item_color = 2'd3; item_valid = 1'b1;
        @(negedge clk);
        item_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({land_pulse, respawn, stack_height, top_color, surface_y, score, lives, game_over}
            !== {2'b00, 4'd0, 2'd0, 10'd440, 8'd0, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL reset_in_land: got lp=%b rs=%b h=%0d top=%0d surf=%0d score=%0d lives=%0d go=%b",
                     land_pulse, respawn, stack_height, top_color, surface_y, score, lives, game_over);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({land_pulse, respawn, score, stack_height} !== {2'b00, 8'd0, 4'd0}) begin
            errors++;
            $display("FAIL land_aborted: got lp=%b rs=%b score=%0d h=%0d want 0 0 0 0",
                     land_pulse, respawn, score, stack_height);
        end
    endtask

    task automatic test_saturation();
        logic lp, mp, rs;
        do_reset();
        for (int t = 0; t < 22; t++) begin
            for (int i = 0; i < 8; i++) begin
                send(10'd300, 10'(424 - 16 * i), 2'(i % 4), 1'b0, lp, mp, rs);
            end
        end
        checks++;
        if ({score, stack_height} !== {8'd255, 4'd0}) begin
            errors++; $display("FAIL score_saturate: got score=%0d h=%0d want 255 0", score, stack_height);
        end
    endtask

    initial begin
        rst = 1'b0; pause = 1'b0; item_valid = 1'b0;
        item_x = '0; item_y = '0; item_color = '0; player_x = 10'd300;
        test_reset();
        test_catch();
        test_miss();
        test_boundaries();
        test_game_over();
        test_tower();
        test_bonus();
        test_pause();
        test_reset_mid_land();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
